// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED codec.
// Parity-count and codeword-layout rules live here so every file agrees on them.
package hamming_pkg;

  typedef enum logic {
    ENCODE = 1'b0,
    DECODE = 1'b1
  } mode_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // Data bit index held at Hamming position pos; -1 marks a parity position.
  function automatic int pos_to_data_idx(input int pos);
    int idx;
    idx = 0;
    if (pos <= 0 || (pos & (pos - 1)) == 0) return -1;
    for (int i = 3; i < pos; i++)
      if ((i & (i - 1)) != 0) idx++;
    return idx;
  endfunction

endpackage

// File: rtl/hamming_secded_codec_if.sv
// Valid/ready stream bundle for the codec: one input beat channel and one
// output beat channel carrying the decode status alongside the data.
interface hamming_secded_codec_if
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4
) ();
  localparam int P      = calc_p(DATA_W);
  localparam int CODE_W = DATA_W + P + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_word;
  logic              out_mode;
  logic [P-1:0]      out_syndrome;
  logic              out_sec;
  logic              out_ded;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_mode, out_syndrome, out_sec, out_ded
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_word, out_mode, out_syndrome, out_sec, out_ded
  );
endinterface

// File: rtl/hamming_core.sv
// Combinational SECDED datapath: builds codewords in encode mode, and computes
// syndrome, overall parity, correction and data extraction in decode mode.
module hamming_core
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 4,
  localparam int P      = calc_p(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  mode_e             mode,
  input  logic [CODE_W-1:0] word,
  output logic [CODE_W-1:0] result,
  output logic [P-1:0]      syndrome,
  output logic              sec,
  output logic              ded
);

  logic [CODE_W-1:0] enc;
  logic [CODE_W-1:0] fixed;
  logic [DATA_W-1:0] data;
  logic [P-1:0]      syn;
  logic              q;
  logic              dec_sec;
  logic              dec_ded;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a value held and infer a latch.
  always_comb begin : encode_path
    enc = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (pos_to_data_idx(pos) >= 0) enc[pos-1] = word[pos_to_data_idx(pos)];
    // Parity positions start at zero, so folding in every covered position is safe.
    for (int k = 0; k < P; k++)
      for (int pos = 1; pos < CODE_W; pos++)
        if (pos[k] && pos != (1 << k)) enc[(1 << k) - 1] ^= enc[pos-1];
    enc[CODE_W-1] = ^enc[CODE_W-2:0];
  end

  always_comb begin : decode_path
    syn = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (word[pos-1]) syn ^= P'(pos);
    q       = ^word;
    fixed   = word;
    dec_sec = 1'b0;
    dec_ded = 1'b0;
    if (q) begin
      if (int'(syn) < CODE_W) begin
        dec_sec = 1'b1;
        // Zero syndrome with odd parity means the overall parity bit itself flipped.
        if (syn == '0) fixed[CODE_W-1] = ~word[CODE_W-1];
        for (int pos = 1; pos < CODE_W; pos++)
          if (int'(syn) == pos) fixed[pos-1] = ~word[pos-1];
      end else begin
        dec_ded = 1'b1;
      end
    end else if (syn != '0) begin
      dec_ded = 1'b1;
    end
    data = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (pos_to_data_idx(pos) >= 0) data[pos_to_data_idx(pos)] = fixed[pos-1];
  end

  assign result   = (mode == ENCODE) ? enc : CODE_W'(data);
  assign syndrome = (mode == ENCODE) ? '0 : syn;
  assign sec      = (mode == DECODE) && dec_sec;
  assign ded      = (mode == DECODE) && dec_ded;

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage valid/ready SECDED codec: S1 registers the input beat, S2 registers
// the hamming_core result; saturating counters track corrected/uncorrectable beats.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hamming_secded_codec_if.slave  bus,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       sec_count,
  output logic [CNT_W-1:0]       ded_count
);
  localparam int P      = calc_p(DATA_W);
  localparam int CODE_W = DATA_W + P + 1;

  logic              ready_en;
  logic              s1_valid;
  mode_e             s1_mode;
  logic [CODE_W-1:0] s1_word;
  logic              s2_valid;
  mode_e             s2_mode;
  logic [CODE_W-1:0] s2_word;
  logic [P-1:0]      s2_syn;
  logic              s2_sec;
  logic              s2_ded;

  logic [CODE_W-1:0] core_word;
  logic [P-1:0]      core_syn;
  logic              core_sec;
  logic              core_ded;
  logic              s1_take;
  logic              s2_take;
  logic              out_fire;

  hamming_core #(.DATA_W(DATA_W)) u_core (
    .mode     (s1_mode),
    .word     (s1_word),
    .result   (core_word),
    .syndrome (core_syn),
    .sec      (core_sec),
    .ded      (core_ded)
  );

  assign out_fire     = s2_valid && bus.out_ready;
  assign s2_take      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = ready_en && (!s1_valid || !s2_valid || bus.out_ready);
  assign s1_take      = bus.in_valid && bus.in_ready;

  // NOTE: payload registers are reset along with the valid bits so nothing from
  // before reset can ever surface on the outputs; ready_en holds in_ready low
  // until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      s1_valid <= 1'b0;
      s1_mode  <= ENCODE;
      s1_word  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (s1_take) begin
        s1_valid <= 1'b1;
        s1_mode  <= mode_e'(bus.in_mode);
        s1_word  <= bus.in_word;
      end else if (s2_take) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= ENCODE;
      s2_word  <= '0;
      s2_syn   <= '0;
      s2_sec   <= 1'b0;
      s2_ded   <= 1'b0;
    end else if (s2_take) begin
      s2_valid <= 1'b1;
      s2_mode  <= s1_mode;
      s2_word  <= core_word;
      s2_syn   <= core_syn;
      s2_sec   <= core_sec;
      s2_ded   <= core_ded;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (cnt_clr) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (out_fire) begin
      if (s2_sec && sec_count != '1) sec_count <= sec_count + CNT_W'(1);
      if (s2_ded && ded_count != '1) ded_count <= ded_count + CNT_W'(1);
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_word     = s2_word;
  assign bus.out_mode     = s2_mode;
  assign bus.out_syndrome = s2_syn;
  assign bus.out_sec      = s2_sec;
  assign bus.out_ded      = s2_ded;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Scoreboard bench for hamming_secded_codec: a driver pushes expected beats from a
// nearest-codeword reference model, a monitor pops and compares each delivered beat.
module tb_hamming_secded_codec;
  import hamming_pkg::*;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int P      = calc_p(DATA_W);
  localparam int CW     = DATA_W + P + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CW-1:0] word;
    logic          mode;
    logic [P-1:0]  syn;
    logic          sec;
    logic          ded;
  } exp_t;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;

  hamming_secded_codec_if #(.DATA_W(DATA_W)) bus ();

  hamming_secded_codec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .sec_count (sec_count),
    .ded_count (ded_count)
  );

  always #5 clk = ~clk;

  int   n_checks  = 0;
  int   n_fail    = 0;
  exp_t sb[$];
  int   model_sec = 0;
  int   model_ded = 0;
  bit   stall     = 1'b0;
  int   rdy_pct   = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword straight from the layout rules: data in non-power-of-two positions,
  // each parity position covers the positions sharing its bit, overall even parity on top.
  function automatic logic [CW-1:0] ref_encode(input logic [DATA_W-1:0] d);
    logic          bits [CW];
    logic          x;
    int            di;
    logic [CW-1:0] cw;
    di = 0;
    for (int pos = 0; pos < CW; pos++) bits[pos] = 1'b0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        bits[pos] = d[di];
        di++;
      end
    for (int pp = 1; pp < CW; pp = pp * 2) begin
      x = 1'b0;
      for (int pos = 1; pos < CW; pos++)
        if ((pos & pp) != 0 && pos != pp) x ^= bits[pos];
      bits[pp] = x;
    end
    cw = '0;
    for (int pos = 1; pos < CW; pos++) cw[pos-1] = bits[pos];
    cw[CW-1] = ^cw[CW-2:0];
    return cw;
  endfunction

  // Decode by brute-force nearest codeword: distance 0 is clean, distance 1 is
  // corrected, anything else is uncorrectable and the raw data bits pass through.
  function automatic exp_t ref_model(input logic mode, input logic [CW-1:0] w);
    exp_t          e;
    int            s;
    int            di;
    logic [CW-1:0] diff;
    e      = '0;
    e.mode = mode;
    if (!mode) begin
      e.word = ref_encode(w[DATA_W-1:0]);
      return e;
    end
    s  = 0;
    di = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if (w[pos-1]) s ^= pos;
      if ((pos & (pos - 1)) != 0) begin
        e.word[di] = w[pos-1];
        di++;
      end
    end
    e.syn = P'(s);
    e.ded = 1'b1;
    for (int d = 0; d < (1 << DATA_W); d++) begin
      diff = ref_encode(DATA_W'(d)) ^ w;
      if ($countones(diff) <= 1) begin
        e.word = CW'(d);
        e.ded  = 1'b0;
        e.sec  = (diff != '0);
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [CW-1:0] word, input logic mode,
                              input logic [P-1:0] syn, input logic sec, input logic ded);
    exp_t e;
    e.word = word;
    e.mode = mode;
    e.syn  = syn;
    e.sec  = sec;
    e.ded  = ded;
    return e;
  endfunction

  function automatic logic [CW-1:0] rand_rx();
    logic [CW-1:0] w;
    int            a;
    int            kind;
    w    = ref_encode(DATA_W'($urandom));
    kind = $urandom_range(0, 3);
    a    = $urandom_range(0, CW - 1);
    if (kind == 1) w[a] = ~w[a];
    if (kind == 2) begin
      w[a] = ~w[a];
      a    = (a + 1 + $urandom_range(0, CW - 2)) % CW;
      w[a] = ~w[a];
    end
    if (kind == 3) w = CW'($urandom);
    return w;
  endfunction

  function automatic logic [CW-1:0] single_err_rx();
    logic [CW-1:0] w;
    int            a;
    w    = ref_encode(DATA_W'($urandom));
    a    = $urandom_range(0, CW - 1);
    w[a] = ~w[a];
    return w;
  endfunction

  task automatic send_exp(input logic mode, input logic [CW-1:0] w, input exp_t e);
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_word  = w;
    #3;
    guard = 0;
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      #3;
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic mode, input logic [CW-1:0] w);
    send_exp(mode, w, ref_model(mode, w));
  endtask

  task automatic send_random();
    logic          m;
    logic [CW-1:0] w;
    m = 1'($urandom_range(0, 1));
    w = m ? rand_rx() : CW'($urandom);
    send(m, w);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: drives out_ready, compares delivered beats, tracks the counter model.
  initial begin
    exp_t e;
    bit   fire_sec;
    bit   fire_ded;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.out_ready = stall ? 1'b0 : ($urandom_range(1, 100) <= rdy_pct);
      #1;
      if (rst_n) begin
        check("sec_count", sec_count, model_sec);
        check("ded_count", ded_count, model_ded);
        fire_sec = 1'b0;
        fire_ded = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", bus.out_valid, 0);
          end else begin
            e = sb.pop_front();
            check("out_word", bus.out_word, e.word);
            check("out_mode", bus.out_mode, e.mode);
            check("out_syndrome", bus.out_syndrome, e.syn);
            check("out_sec", bus.out_sec, e.sec);
            check("out_ded", bus.out_ded, e.ded);
            fire_sec = e.sec;
            fire_ded = e.ded;
          end
        end
        if (cnt_clr) begin
          model_sec = 0;
          model_ded = 0;
        end else begin
          if (fire_sec && model_sec < CMAX) model_sec++;
          if (fire_ded && model_ded < CMAX) model_ded++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'b0;
    bus.in_word  = '0;

    // Reset state and in_ready release timing.
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sec_count", sec_count, 0);
    check("rst_ded_count", ded_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", bus.in_ready, 1);

    // Golden vectors for DATA_W=4.
    send_exp(1'b0, 8'h0B, mk(8'h55, 1'b0, 3'd0, 1'b0, 1'b0));
    send_exp(1'b0, 8'hFB, mk(8'h55, 1'b0, 3'd0, 1'b0, 1'b0));
    send_exp(1'b1, 8'h55, mk(8'h0B, 1'b1, 3'd0, 1'b0, 1'b0));
    send_exp(1'b1, 8'h75, mk(8'h0B, 1'b1, 3'd6, 1'b1, 1'b0));
    drain();
    check("gold_sec_count_1", sec_count, 1);
    send_exp(1'b1, 8'hD5, mk(8'h0B, 1'b1, 3'd0, 1'b1, 1'b0));
    send_exp(1'b1, 8'h56, mk(8'h0B, 1'b1, 3'd3, 1'b0, 1'b1));
    drain();
    check("gold_sec_count_2", sec_count, 2);
    check("gold_ded_count_1", ded_count, 1);

    // Counter clear.
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_sec_count", sec_count, 0);
    check("clr_ded_count", ded_count, 0);

    // Saturation at 2^CNT_W-1, then clear beating a simultaneous increment.
    for (int i = 0; i < 5; i++) send(1'b1, single_err_rx());
    drain();
    check("sat_sec_count", sec_count, CMAX);
    stall = 1'b1;
    send(1'b1, single_err_rx());
    guard = 0;
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      #3;
      guard++;
    end
    check("held_beat_valid", bus.out_valid, 1);
    @(negedge clk);
    stall   = 1'b0;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_beats_inc", sec_count, 0);
    drain();

    // Ten back-to-back mixed beats with a five-cycle output stall midstream.
    fork
      for (int i = 0; i < 10; i++) send_random();
      begin
        repeat (4) @(negedge clk);
        stall = 1'b1;
        repeat (4) begin
          @(negedge clk);
          #3;
          check("stall_out_valid", bus.out_valid, 1);
          check("stall_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        stall = 1'b0;
      end
    join
    drain();

    // Randomized interleaved traffic with random backpressure.
    rdy_pct = 70;
    for (int i = 0; i < 200; i++) send_random();
    drain();
    rdy_pct = 100;

    // Reset with two beats in flight.
    stall = 1'b1;
    send_random();
    send_random();
    @(negedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_sec_count", sec_count, 0);
    check("midrst_ded_count", ded_count, 0);
    sb.delete();
    model_sec = 0;
    model_ded = 0;
    @(negedge clk);
    stall = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    check("post_rst_no_output", bus.out_valid, 0);
    send_random();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
